// File: rtl/score_streamer.sv
// -----------------------------------------------------------------------------
// score_streamer
//
// Collects one frame of N_CLS signed raw class scores. Each score is scaled
// down by an arithmetic right shift and clipped to 12-bit signed range. Once
// the frame is complete, the block replays it as a gap-free burst of N_CLS
// scores in class order for the decision stage.
//
// Ports
//   clk        : single clock, rising-edge
//   rst_n      : asynchronous active-low reset
//   valid_in   : a raw score is present on data_in this cycle
//   data_in    : signed raw class score (IN_W bits), classes 0..N_CLS-1
//   valid_out  : data_out carries a score this cycle
//   data_out   : signed saturated 12-bit score (0 when valid_out is low)
//   busy       : high while the block is emitting a frame
//   drop_err   : sticky, a score arrived while emitting and was discarded
//   sat_err    : sticky, at least one accepted score was clipped
// -----------------------------------------------------------------------------
module score_streamer #(
    parameter int IN_W  = 20,
    parameter int SHIFT = 4,
    parameter int N_CLS = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic signed [IN_W-1:0] data_in,
    output logic                   valid_out,
    output logic signed [11:0]     data_out,
    output logic                   busy,
    output logic                   drop_err,
    output logic                   sat_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [3:0]             LAST_IDX = 4'(N_CLS - 1);
    localparam logic signed [IN_W-1:0] SAT_MAX  = IN_W'(2047);
    localparam logic signed [IN_W-1:0] SAT_MIN  = IN_W'(-2048);

    state_t             state_q, state_d;
    logic [3:0]         wr_idx_q, wr_idx_d;
    logic [3:0]         rd_idx_q, rd_idx_d;
    logic               valid_out_q, valid_out_d;
    logic signed [11:0] data_out_q, data_out_d;
    logic               busy_q, busy_d;
    logic               drop_err_q, drop_err_d;
    logic               sat_err_q, sat_err_d;

    logic signed [11:0] score_buf_q [N_CLS];

    // Scale and clip the incoming score.
    logic signed [IN_W-1:0] shifted;
    logic signed [11:0]     conv_score;
    logic                   clip;

    assign shifted = data_in >>> SHIFT;

    always_comb begin
        conv_score = shifted[11:0];
        clip       = 1'b0;
        if (shifted > SAT_MAX) begin
            conv_score = 12'sd2047;
            clip       = 1'b1;
        end else if (shifted < SAT_MIN) begin
            conv_score = -12'sd2048;
            clip       = 1'b1;
        end
    end

    // Scores are only taken while collecting; anything arriving during the
    // burst is discarded and flagged.
    logic accept;
    logic last_write;
    logic last_read;

    assign accept     = valid_in && (state_q != EMIT);
    assign last_write = accept && (wr_idx_q == LAST_IDX);
    assign last_read  = (state_q == EMIT) && (rd_idx_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    if (last_write) begin
                        // Covers N_CLS == 1 too: IDLE goes straight to EMIT.
                        state_d  = EMIT;
                        wr_idx_d = 4'd0;
                    end else begin
                        state_d  = FILL;
                        wr_idx_d = wr_idx_q + 4'd1;
                    end
                end
            end
            EMIT: begin
                rd_idx_d = rd_idx_q + 4'd1;
                if (last_read) begin
                    state_d  = IDLE;
                    rd_idx_d = 4'd0;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_idx_d = 4'd0;
                rd_idx_d = 4'd0;
            end
        endcase
    end

    // Output registers: data_out is forced to zero outside the burst.
    // busy follows the next state so it is high exactly while state is EMIT.
    always_comb begin
        valid_out_d = (state_q == EMIT);
        data_out_d  = 12'sd0;
        if (state_q == EMIT) begin
            data_out_d = score_buf_q[rd_idx_q];
        end
        busy_d     = (state_d == EMIT);
        drop_err_d = drop_err_q | (valid_in && (state_q == EMIT));
        sat_err_d  = sat_err_q | (accept && clip);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_idx_q    <= 4'd0;
            rd_idx_q    <= 4'd0;
            valid_out_q <= 1'b0;
            data_out_q  <= 12'sd0;
            busy_q      <= 1'b0;
            drop_err_q  <= 1'b0;
            sat_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
            drop_err_q  <= drop_err_d;
            sat_err_q   <= sat_err_d;
        end
    end

    // Frame buffer: one entry written per accepted score at wr_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLS; i++) begin
                score_buf_q[i] <= 12'sd0;
            end
        end else begin
            for (int i = 0; i < N_CLS; i++) begin
                if (accept && (wr_idx_q == 4'(i))) begin
                    score_buf_q[i] <= conv_score;
                end
            end
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign busy      = busy_q;
    assign drop_err  = drop_err_q;
    assign sat_err   = sat_err_q;

endmodule

// File: doc/score_streamer.md
SCORE_STREAMER -- requirements
Module: score_streamer

Interface
REQ-001 The module SHALL have parameter IN_W, default 20: width of signed raw class-score input.
REQ-002 The module SHALL have parameter SHIFT, default 4: arithmetic right-shift applied to each raw score before saturation.
REQ-003 The module SHALL have parameter N_CLS, default 10: scores per frame.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port valid_in  input  1  raw score present on data_in this cycle.
REQ-007 Port data_in  input  IN_W  signed raw class score, class order 0..N_CLS-1.
REQ-008 Port valid_out  output  1  data_out carries a score this cycle.
REQ-009 Port data_out  output  12  signed saturated score for the decision stage.
REQ-010 Port busy  output  1  high while the block is in EMIT.
REQ-011 Port drop_err  output  1  sticky: an input was dropped.
REQ-012 Port sat_err  output  1  sticky: at least one score was saturated.

Function
REQ-013 The block SHALL convert each accepted score as: s = data_in >>> SHIFT (arithmetic); if s > 2047 store 2047; if s < -2048 store -2048; else store s[11:0].
REQ-014 The block SHALL hold N_CLS converted scores in a register buffer indexed by a 4-bit write counter wr_idx.
REQ-015 The FSM SHALL have states IDLE, FILL, EMIT; reset state IDLE.
REQ-016 In IDLE or FILL, valid_in=1 SHALL store the converted score at buffer[wr_idx] and increment wr_idx.
REQ-017 IDLE -> FILL on an accepted score when N_CLS>1; FILL stays FILL while wr_idx < N_CLS-1 after the write.
REQ-018 When the score written has wr_idx = N_CLS-1, the FSM SHALL go to EMIT on the next edge and clear wr_idx to 0.
REQ-019 In IDLE/FILL with valid_in=0, no state change SHALL occur; gaps between input scores are permitted without limit.
REQ-020 In EMIT, a 4-bit read counter rd_idx SHALL start at 0; each EMIT cycle SHALL drive valid_out=1, data_out=buffer[rd_idx] (registered), and increment rd_idx.
REQ-021 valid_out SHALL be high for exactly N_CLS consecutive cycles per frame, scores in class order 0..N_CLS-1, with no gaps.
REQ-022 Latency: last input accepted at edge T -> valid_out high for the cycles following edges T+1 .. T+N_CLS.
REQ-023 After the edge emitting rd_idx = N_CLS-1, the FSM SHALL return to IDLE and clear rd_idx; the next valid_in is accepted in the following cycle.
REQ-024 valid_in=1 sampled while in EMIT SHALL be discarded (buffer, wr_idx unchanged) and SHALL set drop_err.
REQ-025 When valid_out=0, data_out SHALL be 12'd0.
REQ-026 busy SHALL equal (state == EMIT), registered.
REQ-027 sat_err SHALL set on any accepted score that clips under REQ-013; drop_err and sat_err clear only on reset.
REQ-028 A partial frame (fewer than N_CLS scores) SHALL wait in FILL indefinitely; no timeout.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, wr_idx=0, rd_idx=0, valid_out=0, data_out=0, busy=0, drop_err=0, sat_err=0, all buffer entries 0.
REQ-030 Reset asserted mid-FILL or mid-EMIT SHALL abandon the frame; no further valid_out until a complete new frame of N_CLS scores is accepted after release.
REQ-031 The first rising edge with rst_n=1 SHALL be a normal operating edge.

Verification
REQ-032 Frame: raw 16*k for k=0..9 on 10 consecutive cycles -> valid_out 10 consecutive cycles starting one cycle after last input, data_out 0,1,..,9, sat_err=0.
REQ-033 Saturation: raw 20'sh7FFFF and 20'sh80000 as classes 0,1 -> data_out 2047 then -2048, sat_err=1 afterwards.
REQ-034 Gapped input: 10 scores with random 0-5 idle cycles between -> identical output stream, no drops, drop_err=0.
REQ-035 Overrun: valid_in held 1 for 13 cycles -> first 10 emitted, inputs during EMIT dropped, drop_err=1, busy high exactly 10 cycles.
REQ-036 Reset mid-EMIT after 4 scores emitted -> valid_out and busy low asynchronously; fresh frame after release emits 10 new scores correctly.
REQ-037 Back-to-back: second frame starts the cycle after busy falls -> two complete 10-score bursts, second buffer contents only.
